frog_input_conditioner: RTL
===========================

# frog_input_conditioner

Parametrised front-end for the game's push-button inputs: synchronises N active-low raw buttons, debounces each channel, detects presses, optionally generates auto-repeat, and presents one move event at a time to the game core over a valid/ready handshake. Sits between the board pins (up/down/left/right, idle-high) and the frogger movement logic. It replaces per-button ad-hoc edge logic and adds multi-channel arbitration and overrun reporting.

## Interface
- NUM_CH, 4, number of button channels (index 0=up, 1=down, 2=left, 3=right for the default).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (≥1).
- REPEAT_DELAY, 50_000_000, held cycles after a press before the first repeat event (≥1).
- REPEAT_PERIOD, 12_500_000, cycles between subsequent repeat events (≥1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_n  in  NUM_CH  raw buttons, active-low (1 = released); asynchronous to clk.
- btn_held  out  NUM_CH  debounced level, 1 = pressed.
- move_valid  out  1  a move event is pending.
- move_idx  out  $clog2(NUM_CH) (min 1)  channel of the presented event.
- move_ready  in  1  consumer accepts the event this cycle.
- overrun  out  1  sticky; set when an event arrives on a channel whose pending flag is already set; cleared only by reset.

## Operation
- Per channel: 2-flop synchroniser (reset to 1 = released) → debounce counter → debounced state.
- Debounce: counter resets to 0 whenever synchronised sample equals debounced state; otherwise increments; when it reaches DEBOUNCE_CYCLES, debounced state flips and counter clears. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press event: debounced state released→pressed. Release produces no event.
- Each channel has a 1-bit pending flag, set on event, cleared on acceptance.
- Arbiter: fixed priority, lowest index wins. move_valid = |pending; move_idx = lowest set pending bit; both combinational from pending flags.
- Acceptance: move_valid && move_ready clears pending[move_idx] at the clock edge.
- Simultaneous accept and new event on the same channel: flag stays set (set wins), no overrun.
- Event on a channel already pending and not being accepted that cycle: coalesced, overrun set.
- move_idx is stable while move_valid is high and no higher-priority channel becomes pending; a higher-priority event may preempt before acceptance (consumer samples only on handshake).
- Counter widths: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1); no wrap, counters saturate at their terminal value until reloaded.

## Timing
- Reset (asserted, async): btn_held=0, pending=0, move_valid=0, move_idx=0, overrun=0, all counters 0, synchronisers 1. Release is synchronous to clk.
- btn_n falling at edge t (stable thereafter): btn_held rises at t+2+DEBOUNCE_CYCLES; move_valid rises one cycle later.
- Release latency identical: btn_held falls DEBOUNCE_CYCLES+2 cycles after btn_n rises.
- Accepted event: move_valid falls the cycle after the handshake unless other flags are pending.
- Reset asserted mid-hold or mid-debounce: everything returns to reset values; a button still held after reset release is debounced afresh and produces one press event.

## Configuration
- FROG_INPUT_REPEAT_EN defined: while btn_held[i]=1, a repeat counter runs; first repeat event REPEAT_DELAY cycles after btn_held rose, then every REPEAT_PERIOD cycles; repeat events use the same pending/overrun path; counter clears on release.
- Undefined: no repeat logic; exactly one event per press; REPEAT_* parameters unused.

## Structure
- Package frog_pkg: channel index constants (CH_UP=0, CH_DOWN=1, CH_LEFT=2, CH_RIGHT=3), NUM_DIRS=4, default timing constants.
- One sub-module frog_debounce (single channel: synchroniser, debounce counter, press pulse, optional repeat), instantiated NUM_CH times by generate; arbiter and pending flags live in the top.

## Test plan
Bench parameters: NUM_CH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Hold btn_n[2]=0 from edge 20, move_ready=1 -> btn_held[2] rises at edge 26, single move_valid cycle at 27 with move_idx=2.
- Pulse btn_n[0] low for 3 cycles -> btn_held and move_valid never assert.
- btn_n[1] and btn_n[3] fall same cycle, move_ready=0 for 10 cycles then 1 -> move_idx=1 accepted first, then 3 next cycle; overrun=0.
- Two debounced presses on channel 0 with move_ready=0 throughout -> overrun=1, single pending event, overrun remains 1 after acceptance.
- FROG_INPUT_REPEAT_EN, hold btn_n[3] 40 cycles, move_ready=1 -> events at press, +10, +15, +20, +25, ... until release; none after release. Without macro -> exactly one event.
- Assert reset while btn_n[0] held and pending -> all outputs 0 asynchronously; after release, one new event at 2+4+1 cycles.

Source files
------------

// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - channel indices, default timing and counter sizing for the frog input front-end
package frog_pkg;

  localparam int CH_UP    = 0;
  localparam int CH_DOWN  = 1;
  localparam int CH_LEFT  = 2;
  localparam int CH_RIGHT = 3;
  localparam int NUM_DIRS = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 12_500_000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // One width serves both the debounce and repeat counters so neither can wrap.
  function automatic int counter_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frog_debounce.sv
// rtl/frog_debounce.sv - one button: 2-flop synchroniser, debounce, press pulse
// FROG_INPUT_REPEAT_EN adds auto-repeat pulses while the button stays held.
module frog_debounce
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic held,
  output logic event_pulse
);

  localparam int CW = counter_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic          sync1;
  logic          sync2;
  logic          held_d;
  logic          sample_pressed;
  logic          press;
  logic [CW-1:0] db_cnt;

  assign sample_pressed = ~sync2;
  assign press          = held & ~held_d;

  // A level change is taken only after DEBOUNCE_CYCLES agreeing samples plus the one that flips it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      held   <= 1'b0;
      held_d <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1  <= btn_n;
      sync2  <= sync1;
      held_d <= held;
      if (sample_pressed == held) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES)) begin
        held   <= ~held;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

`ifdef FROG_INPUT_REPEAT_EN
  logic [CW-1:0] rep_cnt;
  logic          rep_late;
  logic          rep_fire;

  assign rep_fire = held &&
                    (rep_cnt == (rep_late ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY)));

  // The reload value is 1 because the firing cycle itself counts towards the next period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt  <= '0;
      rep_late <= 1'b0;
    end else if (!held) begin
      rep_cnt  <= '0;
      rep_late <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt  <= CW'(1);
      rep_late <= 1'b1;
    end else begin
      rep_cnt  <= rep_cnt + CW'(1);
    end
  end

  assign event_pulse = press | rep_fire;
`else
  assign event_pulse = press;
`endif

endmodule

// File: rtl/frog_input_conditioner.sv
// rtl/frog_input_conditioner.sv - N-button conditioner with pending flags, fixed-priority arbiter, overrun flag
// FROG_INPUT_REPEAT_EN (in frog_debounce) enables auto-repeat events.
module frog_input_conditioner
  import frog_pkg::*;
#(
  parameter int NUM_CH          = NUM_DIRS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  localparam int IW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_n,
  output logic [NUM_CH-1:0] btn_held,
  output logic              move_valid,
  output logic [IW-1:0]     move_idx,
  input  logic              move_ready,
  output logic              overrun
);

  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] accept;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    frog_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (btn_n[gi]),
      .held       (btn_held[gi]),
      .event_pulse(ev[gi])
    );
  end

  // Scanning downwards leaves the lowest pending index, giving channel 0 top priority.
  always_comb begin
    move_idx   = '0;
    move_valid = |pending;
    accept     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) move_idx = IW'(i);
    end
    if (move_valid && move_ready) accept[move_idx] = 1'b1;
  end

  // A new event beats a same-cycle acceptance; only an unaccepted collision is an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= ev | (pending & ~accept);
      if (|(ev & pending & ~accept)) overrun <= 1'b1;
    end
  end

endmodule
